// File: rtl/fifo_byte_serializer_if.sv
// FIFO read-port bundle between the dual-clock FIFO (master) and the byte serializer (slave).
// Carries show-ahead read data, the empty flag and the one-cycle pop strobe.
interface fifo_byte_serializer_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] rdata;
    logic                rempty;
    logic                rinc;

    modport master (
        output rdata,
        output rempty,
        input  rinc
    );

    modport slave (
        input  rdata,
        input  rempty,
        output rinc
    );
endinterface

// File: rtl/fifo_byte_serializer.sv
// Pops bytes from the FIFO read port and shifts them out one bit per tick, then samples an ACK slot.
// Optional macro SER_LSB_FIRST_EN: bits go out LSB first instead of MSB first.
module fifo_byte_serializer #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    fifo_byte_serializer_if.slave   fifo,
    input  logic                    bit_tick_i,
    input  logic                    ack_i,
    output logic                    sda_o,
    output logic                    busy_o,
    output logic                    byte_done_o,
    output logic                    nack_o,
    output logic [CNTSIZE-1:0]      byte_cnt_o
);
    localparam int BCW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATASIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                state_q;
    logic [DATASIZE-1:0]   shreg_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic                  sda_q;
    logic                  rinc_q;
    logic                  busy_q;
    logic                  byte_done_q;
    logic                  nack_q;
    logic [CNTSIZE-1:0]    byte_cnt_q;

`ifdef SER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATASIZE-1:0] w);
        return w[0];
    endfunction

    function automatic logic next_bit(input logic [DATASIZE-1:0] w);
        return w[1];
    endfunction

    function automatic logic [DATASIZE-1:0] shift_word(input logic [DATASIZE-1:0] w);
        return w >> 1;
    endfunction
`else
    function automatic logic first_bit(input logic [DATASIZE-1:0] w);
        return w[DATASIZE-1];
    endfunction

    function automatic logic next_bit(input logic [DATASIZE-1:0] w);
        return w[DATASIZE-2];
    endfunction

    function automatic logic [DATASIZE-1:0] shift_word(input logic [DATASIZE-1:0] w);
        return w << 1;
    endfunction
`endif

    // Frame FSM with all outputs registered; rinc and byte_done default low so they pulse for one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sda_q       <= 1'b1;
            rinc_q      <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            nack_q      <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            rinc_q      <= 1'b0;
            byte_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sda_q <= 1'b1;
                    if (enable_i && !fifo.rempty) begin
                        shreg_q   <= fifo.rdata;
                        sda_q     <= first_bit(fifo.rdata);
                        bit_cnt_q <= '0;
                        rinc_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_tick_i) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            sda_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else begin
                            shreg_q   <= shift_word(shreg_q);
                            sda_q     <= next_bit(shreg_q);
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_ACK: begin
                    sda_q <= 1'b1;
                    if (bit_tick_i) begin
                        if (!ack_i) begin
                            byte_done_q <= 1'b1;
                            byte_cnt_q  <= byte_cnt_q + CNTSIZE'(1);
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            nack_q  <= 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    sda_q <= 1'b1;
                    if (!enable_i) begin
                        nack_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    sda_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo.rinc   = rinc_q;
    assign sda_o       = sda_q;
    assign busy_o      = busy_q;
    assign byte_done_o = byte_done_q;
    assign nack_o      = nack_q;
    assign byte_cnt_o  = byte_cnt_q;
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed plus randomized bench for fifo_byte_serializer against a queue-based FIFO and a bit-order model.
module tb_fifo_byte_serializer;
    localparam int DS = 8;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       bit_tick;
    logic       ack;
    logic       sda;
    logic       busy;
    logic       byte_done;
    logic       nack;
    logic [7:0] byte_cnt;

    fifo_byte_serializer_if #(.DATASIZE(DS)) fif ();

    fifo_byte_serializer #(.DATASIZE(DS), .CNTSIZE(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .fifo        (fif),
        .bit_tick_i  (bit_tick),
        .ack_i       (ack),
        .sda_o       (sda),
        .busy_o      (busy),
        .byte_done_o (byte_done),
        .nack_o      (nack),
        .byte_cnt_o  (byte_cnt)
    );

    int         checks = 0;
    int         failures = 0;
    int         pops = 0;
    logic       rinc_prev = 1'b0;
    logic [7:0] q[$];
    logic [7:0] exp_cnt = 8'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_bit(input logic [7:0] b, input int i);
`ifdef SER_LSB_FIRST_EN
        return 1'((b >> i) & 8'd1);
`else
        return 1'((b >> (DS - 1 - i)) & 8'd1);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fif.rempty = (q.size() == 0);
        fif.rdata  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    // One clock: the FIFO pops at the edge where rinc was high; outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rinc_prev) begin
            pops++;
            if (q.size() != 0) void'(q.pop_front());
        end
        rinc_prev = fif.rinc;
        refresh();
    endtask

    task automatic tick();
        bit_tick = 1'b1;
        cyc();
        bit_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic ackv, input int gap,
                              input logic tick_on_load, input int drop_bit);
        int p0;
        p0 = pops;
        bit_tick = tick_on_load;
        cyc();
        bit_tick = 1'b0;
        check("load_rinc", 32'(fif.rinc), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("bit0", 32'(sda), 32'(exp_bit(b, 0)));
        for (int i = 1; i <= DS; i++) begin
            for (int g = 1; g < gap; g++) begin
                cyc();
                check("hold_bit", 32'(sda), 32'(exp_bit(b, i - 1)));
                check("hold_rinc", 32'(fif.rinc), 32'd0);
            end
            if (i == drop_bit) enable = 1'b0;
            tick();
            if (i < DS) check("data_bit", 32'(sda), 32'(exp_bit(b, i)));
            else        check("ack_slot_sda", 32'(sda), 32'd1);
        end
        for (int g = 1; g < gap; g++) begin
            cyc();
            check("ack_wait_busy", 32'(busy), 32'd1);
        end
        ack = ackv;
        tick();
        ack = 1'b0;
        if (!ackv) begin
            exp_cnt = exp_cnt + 8'd1;
            check("byte_done", 32'(byte_done), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("no_nack", 32'(nack), 32'd0);
        end else begin
            check("nack_set", 32'(nack), 32'd1);
            check("nack_no_done", 32'(byte_done), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        check("byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
        check("one_pop", 32'(pops), 32'(p0 + 1));
    endtask

    initial begin
        int p0;
        int acked;
        int frames;
        logic       ackv;
        logic [7:0] b;

        rst_n = 1'b0; enable = 1'b1; bit_tick = 1'b0; ack = 1'b0;
        push(8'h5A);

        // Reset held with a ready FIFO and toggling tick
        for (int i = 0; i < 3; i++) begin
            bit_tick = ~bit_tick;
            cyc();
            check("rst_sda", 32'(sda), 32'd1);
            check("rst_rinc", 32'(fif.rinc), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_nack", 32'(nack), 32'd0);
            check("rst_cnt", 32'(byte_cnt), 32'd0);
        end
        bit_tick = 1'b0;
        check("rst_no_pop", 32'(pops), 32'd0);
        q.delete();
        refresh();
        rst_n = 1'b1;
        cyc();

        // Single byte A5, tick every 4 clocks
        push(8'hA5);
        send_frame(8'hA5, 1'b0, 4, 1'b0, -1);
        cyc();
        check("done_pulse_end", 32'(byte_done), 32'd0);
        check("single_cnt", 32'(byte_cnt), 32'd1);

        // Empty FIFO with enable high
        p0 = pops;
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("empty_rinc", 32'(fif.rinc), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_sda", 32'(sda), 32'd1);
        end
        check("empty_no_pop", 32'(pops), 32'(p0));

        // NACK then hold with data available, released by dropping enable
        push(8'h3C);
        send_frame(8'h3C, 1'b1, 2, 1'b0, -1);
        push(8'h77);
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_no_rinc", 32'(fif.rinc), 32'd0);
            check("hold_sda", 32'(sda), 32'd1);
            check("hold_nack", 32'(nack), 32'd1);
        end
        check("hold_no_pop", 32'(pops), 32'(p0));
        enable = 1'b0;
        cyc();
        check("release_nack", 32'(nack), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        q.delete();
        refresh();
        enable = 1'b1;

        // Stream of three bytes, all ACKed
        p0 = pops;
        push(8'h01); push(8'h80); push(8'hFF);
        send_frame(8'h01, 1'b0, 1, 1'b1, -1);
        send_frame(8'h80, 1'b0, 2, 1'b0, -1);
        send_frame(8'hFF, 1'b0, 1, 1'b0, -1);
        cyc();
        check("stream_pops", 32'(pops), 32'(p0 + 3));
        check("stream_cnt", 32'(byte_cnt), 32'(exp_cnt));

        // Same stream shape with enable dropped during byte 2
        p0 = pops;
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        send_frame(q[0], 1'b0, 1, 1'b0, -1);
        send_frame(q[0], 1'b0, 2, 1'b0, 3);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("drop_no_rinc", 32'(fif.rinc), 32'd0);
            check("drop_busy", 32'(busy), 32'd0);
        end
        check("drop_pops", 32'(pops), 32'(p0 + 2));
        check("drop_left", 32'(q.size()), 32'd1);
        q.delete();
        refresh();
        enable = 1'b1;

        // Random bytes, gaps and occasional NACKs; runs past the counter wrap
        acked = 0;
        frames = 0;
        while (acked < 262 && frames < 400) begin
            b = 8'($urandom);
            ackv = ($urandom_range(0, 9) == 0);
            push(b);
            send_frame(b, ackv, int'($urandom_range(1, 3)), 1'($urandom), -1);
            frames++;
            if (ackv) begin
                enable = 1'b0;
                cyc();
                check("rnd_release", 32'(nack), 32'd0);
                enable = 1'b1;
            end else begin
                acked++;
            end
        end
        cyc();
        check("rnd_cnt_wrap", 32'(byte_cnt), 32'(exp_cnt));

        // Mid-frame reset after three ticks of F0; next word starts from its first bit
        push(8'hF0); push(8'h5A);
        cyc();
        check("mr_load", 32'(fif.rinc), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("mr_bit", 32'(sda), 32'(exp_bit(8'hF0, i)));
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        check("mr_sda", 32'(sda), 32'd1);
        check("mr_rinc", 32'(fif.rinc), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_nack", 32'(nack), 32'd0);
        check("mr_done", 32'(byte_done), 32'd0);
        check("mr_cnt", 32'(byte_cnt), 32'd0);
        send_frame(8'h5A, 1'b0, 2, 1'b0, -1);
        check("mr_after_cnt", 32'(byte_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
